// File: rtl/register_file_bist_pkg.sv
// Shared definitions for the register-file built-in self-test.
//   state_t         : sweep controller states
//   REGISTER_COUNT  : number of registers swept (32)
//   base_pattern()  : pattern table, one 32-bit base word per pass
//   pattern_data()  : value written to register i on pass k
//   expected_data() : value a healthy register file returns for (k, i)
package register_file_bist_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int REGISTER_COUNT = 32;

    function automatic logic [31:0] base_pattern(input logic [1:0] k);
        logic [31:0] base;
        case (k)
            2'd0:    base = 32'h0000_0000;
            2'd1:    base = 32'hffff_ffff;
            2'd2:    base = 32'h5555_5555;
            default: base = 32'haaaa_aaaa;
        endcase
        return base;
    endfunction

    // XOR with the index makes every register hold a distinct word, which
    // catches address aliasing as well as stuck data bits.
    function automatic logic [31:0] pattern_data(input logic [1:0] k, input logic [4:0] i);
        return base_pattern(k) ^ {27'd0, i};
    endfunction

    function automatic logic [31:0] expected_data(input logic [1:0] k, input logic [4:0] i,
                                                  input logic hardwired);
        logic [31:0] value;
        if (hardwired && (i == 5'd0)) value = 32'h0;
        else                          value = pattern_data(k, i);
        return value;
    endfunction

endpackage

// File: rtl/register_file_bist.sv
// Built-in self-test initiator for the 32x32 register file.
// Writes a pattern into every register, reads all of them back through both
// read ports (port 1 ascending, port 2 descending), and repeats for
// PATTERN_COUNT patterns. Stops at the first mismatch and latches its location.
//
// Ports:
//   clock, reset            : system clock; synchronous active-high reset
//   start                   : level request, only looked at in IDLE or DONE
//   busy, done, passed      : sweep status; passed is meaningful while done=1
//   fail_address/port/pattern : first mismatch (register, 0=port1/1=port2, pass)
//   write_enabled/address/data : register-file write port
//   read_address_1/2, read_data_1/2 : register-file read ports (combinational data)
//
// Start protocol: start is a level. It is accepted on any rising edge where the
// controller is in IDLE or DONE; busy is high from the next cycle until the
// sweep ends, and done then stays high until the next accepted start or reset.
// start seen while busy has no effect.
module register_file_bist
    import register_file_bist_pkg::*;
#(
    parameter int PATTERN_COUNT           = 4,
    parameter bit ZERO_REGISTER_HARDWIRED = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        passed,
    output logic [4:0]  fail_address,
    output logic        fail_port,
    output logic [1:0]  fail_pattern,
    output logic        write_enabled,
    output logic [4:0]  write_address,
    output logic [31:0] write_data,
    output logic [4:0]  read_address_1,
    input  logic [31:0] read_data_1,
    output logic [4:0]  read_address_2,
    input  logic [31:0] read_data_2
);

    localparam logic [4:0] LAST_INDEX   = 5'(REGISTER_COUNT - 1);
    localparam logic [1:0] LAST_PATTERN = 2'(PATTERN_COUNT - 1);

    // Controller state; kept as a named register so checkers can observe it.
    state_t     state;
    logic [1:0] k;
    logic [4:0] i;

    logic [31:0] expected_1;
    logic [31:0] expected_2;
    logic        mismatch_1;
    logic        mismatch_2;

    // Port 2 walks the registers in reverse, so its address is ~i (= 31-i).
    assign expected_1 = expected_data(k, i, ZERO_REGISTER_HARDWIRED);
    assign expected_2 = expected_data(k, ~i, ZERO_REGISTER_HARDWIRED);
    assign mismatch_1 = (read_data_1 != expected_1);
    assign mismatch_2 = (read_data_2 != expected_2);

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            k              <= 2'd0;
            i              <= 5'd0;
            busy           <= 1'b0;
            done           <= 1'b0;
            passed         <= 1'b0;
            fail_address   <= 5'd0;
            fail_port      <= 1'b0;
            fail_pattern   <= 2'd0;
            write_enabled  <= 1'b0;
            write_address  <= 5'd0;
            write_data     <= 32'd0;
            read_address_1 <= 5'd0;
            read_address_2 <= 5'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state          <= WRITE;
                        k              <= 2'd0;
                        i              <= 5'd0;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        passed         <= 1'b0;
                        fail_address   <= 5'd0;
                        fail_port      <= 1'b0;
                        fail_pattern   <= 2'd0;
                        write_enabled  <= 1'b1;
                        write_address  <= 5'd0;
                        write_data     <= pattern_data(2'd0, 5'd0);
                        read_address_1 <= 5'd0;
                        read_address_2 <= 5'd0;
                    end
                end

                WRITE: begin
                    if (i == LAST_INDEX) begin
                        state          <= READ;
                        i              <= 5'd0;
                        write_enabled  <= 1'b0;
                        write_address  <= 5'd0;
                        write_data     <= 32'd0;
                        read_address_1 <= 5'd0;
                        read_address_2 <= LAST_INDEX;
                    end else begin
                        i             <= i + 5'd1;
                        write_address <= i + 5'd1;
                        write_data    <= pattern_data(k, i + 5'd1);
                    end
                end

                READ: begin
                    if (mismatch_1 || mismatch_2) begin
                        // Port 1 wins a tie so the report is deterministic.
                        state          <= DONE;
                        busy           <= 1'b0;
                        done           <= 1'b1;
                        passed         <= 1'b0;
                        fail_port      <= ~mismatch_1;
                        fail_address   <= mismatch_1 ? i : ~i;
                        fail_pattern   <= k;
                        read_address_1 <= 5'd0;
                        read_address_2 <= 5'd0;
                    end else if (i == LAST_INDEX) begin
                        i              <= 5'd0;
                        read_address_1 <= 5'd0;
                        read_address_2 <= 5'd0;
                        if (k == LAST_PATTERN) begin
                            state  <= DONE;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                            passed <= 1'b1;
                        end else begin
                            state         <= WRITE;
                            k             <= k + 2'd1;
                            write_enabled <= 1'b1;
                            write_address <= 5'd0;
                            write_data    <= pattern_data(k + 2'd1, 5'd0);
                        end
                    end else begin
                        i              <= i + 5'd1;
                        read_address_1 <= i + 5'd1;
                        read_address_2 <= ~(i + 5'd1);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_register_file_bist.sv
module tb_register_file_bist;
    import register_file_bist_pkg::*;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // ---------------- DUT with 4 patterns ----------------
    logic        start;
    logic        busy, done, passed, fail_port, write_enabled;
    logic [4:0]  fail_address, write_address, read_address_1, read_address_2;
    logic [1:0]  fail_pattern;
    logic [31:0] write_data, read_data_1, read_data_2;

    register_file_bist #(.PATTERN_COUNT(4), .ZERO_REGISTER_HARDWIRED(1'b1)) dut (
        .clock(clock), .reset(reset), .start(start),
        .busy(busy), .done(done), .passed(passed),
        .fail_address(fail_address), .fail_port(fail_port), .fail_pattern(fail_pattern),
        .write_enabled(write_enabled), .write_address(write_address), .write_data(write_data),
        .read_address_1(read_address_1), .read_data_1(read_data_1),
        .read_address_2(read_address_2), .read_data_2(read_data_2)
    );

    // ---------------- DUT with a single pattern ----------------
    logic        start1;
    logic        busy1, done1, passed1, fail_port1, write_enabled1;
    logic [4:0]  fail_address1, write_address1, read_address_11, read_address_21;
    logic [1:0]  fail_pattern1;
    logic [31:0] write_data1, read_data_11, read_data_21;

    register_file_bist #(.PATTERN_COUNT(1), .ZERO_REGISTER_HARDWIRED(1'b1)) dut1 (
        .clock(clock), .reset(reset), .start(start1),
        .busy(busy1), .done(done1), .passed(passed1),
        .fail_address(fail_address1), .fail_port(fail_port1), .fail_pattern(fail_pattern1),
        .write_enabled(write_enabled1), .write_address(write_address1), .write_data(write_data1),
        .read_address_1(read_address_11), .read_data_1(read_data_11),
        .read_address_2(read_address_21), .read_data_2(read_data_21)
    );

    // ---------------- behavioural register files ----------------
    // fault_mode: 0 healthy, 1 reg16 bit0 stuck-at-1 (storage, both ports),
    // 2 reg16 bit0 stuck-at-1 on port 1 only, 3 port 2 reads reg[addr^1],
    // 4 bit0 inverted on both ports, 5 reg9 bit4 flips when it holds aaaaaaa3,
    // 6 reg5 bit31 stuck-at-0.
    int          fault_mode = 0;
    logic [31:0] mem  [32];
    logic [31:0] mem1 [32];
    logic [4:0]  a2;

    always @(posedge clock) if (write_enabled)  mem[write_address]   <= write_data;
    always @(posedge clock) if (write_enabled1) mem1[write_address1] <= write_data1;

    function automatic logic [31:0] faulty_read(input logic [4:0] a, input logic [31:0] stored,
                                                input int fm);
        logic [31:0] v;
        v = (a == 5'd0) ? 32'd0 : stored;
        if (fm == 1 && a == 5'd16) v[0] = 1'b1;
        if (fm == 6 && a == 5'd5) v[31] = 1'b0;
        if (fm == 5 && a == 5'd9 && stored == 32'haaaa_aaa3) v[4] = ~v[4];
        return v;
    endfunction

    always_comb begin
        a2 = (fault_mode == 3) ? (read_address_2 ^ 5'd1) : read_address_2;
        read_data_1 = faulty_read(read_address_1, mem[read_address_1], fault_mode);
        read_data_2 = faulty_read(a2, mem[a2], fault_mode);
        if (fault_mode == 2 && read_address_1 == 5'd16) read_data_1[0] = 1'b1;
        if (fault_mode == 4) begin
            read_data_1 = read_data_1 ^ 32'd1;
            read_data_2 = read_data_2 ^ 32'd1;
        end
        read_data_11 = faulty_read(read_address_11, mem1[read_address_11], 0);
        read_data_21 = faulty_read(read_address_21, mem1[read_address_21], 0);
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Pulses start for one cycle, then counts clock edges from the edge that
    // raised busy until done is seen. Optionally re-pulses start mid-sweep.
    task automatic run_sweep(input int fm, input int pulse_at, output int lat);
        fault_mode = fm;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("first_busy", busy, 1'b1);
        check("first_cleared", {done, passed, fail_address, fail_port, fail_pattern}, 0);
        check("first_write", {write_enabled, write_address, write_data}, {1'b1, 5'd0, 32'd0});
        lat = 0;
        while (!done && lat < 600) begin
            @(negedge clock);
            lat++;
            start = (lat == pulse_at);
        end
        start = 1'b0;
        check("done_after_sweep", done, 1'b1);
        check("idle_outputs", {busy, write_enabled}, 0);
    endtask

    typedef struct {
        int         fault;
        int         latency;
        logic       passed;
        logic [4:0] address;
        logic       port;
        logic [1:0] pattern;
    } vec_t;

    vec_t vecs[7];
    int   lat;
    int   hold;

    initial begin
        vecs[0] = '{0, 256, 1'b1, 5'd0,  1'b0, 2'd0};
        // Storage fault: port 2 reaches reg16 at i=15, before port 1 does at i=16.
        vecs[1] = '{1, 48,  1'b0, 5'd16, 1'b1, 2'd0};
        vecs[2] = '{2, 49,  1'b0, 5'd16, 1'b0, 2'd0};
        vecs[3] = '{3, 33,  1'b0, 5'd31, 1'b1, 2'd0};
        vecs[4] = '{4, 33,  1'b0, 5'd0,  1'b0, 2'd0};
        vecs[5] = '{6, 102, 1'b0, 5'd5,  1'b0, 2'd1};
        vecs[6] = '{5, 234, 1'b0, 5'd9,  1'b0, 2'd3};

        start  = 1'b0;
        start1 = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;

        // reset state
        check("reset_state", 32'(dut.state), 32'(IDLE));
        check("reset_status", {busy, done, passed, fail_address, fail_port, fail_pattern}, 0);
        check("reset_ports", {write_enabled, write_address, write_data, read_address_1, read_address_2}, 0);

        // table-driven sweeps
        foreach (vecs[n]) begin
            run_sweep(vecs[n].fault, 0, lat);
            check($sformatf("latency_%0d", n), lat, vecs[n].latency);
            check($sformatf("passed_%0d", n), passed, vecs[n].passed);
            check($sformatf("fail_address_%0d", n), fail_address, vecs[n].address);
            check($sformatf("fail_port_%0d", n), fail_port, vecs[n].port);
            check($sformatf("fail_pattern_%0d", n), fail_pattern, vecs[n].pattern);
        end

        // done holds while start stays low
        repeat (3) @(negedge clock);
        check("done_holds", {done, busy}, 2'b10);

        // reset at cycle 40 of busy
        fault_mode = 0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (39) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("midreset_status", {busy, write_enabled, done}, 0);
        check("midreset_state", 32'(dut.state), 32'(IDLE));
        run_sweep(0, 0, lat);
        check("after_reset_latency", lat, 256);
        check("after_reset_passed", passed, 1'b1);

        // start re-pulsed at cycle 10 of busy has no effect
        run_sweep(0, 9, lat);
        check("ignored_start_latency", lat, 256);
        check("ignored_start_passed", passed, 1'b1);

        // start held high: done lasts one cycle, busy returns next cycle
        start = 1'b1;
        hold = 0;
        @(negedge clock);
        while (!done && hold < 600) begin
            @(negedge clock);
            hold++;
        end
        check("held_latency", hold, 256);
        check("held_done_seen", {done, busy}, 2'b10);
        @(negedge clock);
        check("held_restart", {done, busy}, 2'b01);
        start = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;

        // single-pattern instance
        start1 = 1'b1;
        @(negedge clock);
        start1 = 1'b0;
        check("single_busy", busy1, 1'b1);
        lat = 0;
        while (!done1 && lat < 600) begin
            @(negedge clock);
            lat++;
        end
        check("single_latency", lat, 64);
        check("single_result", {done1, passed1, fail_pattern1, fail_address1}, {1'b1, 1'b1, 2'd0, 5'd0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
